// File: rtl/rng_ram_arbiter.sv
// Round-robin arbiter sharing the RNG key RAM Wishbone port B between NREQ
// single-beat requesters, with a strobe-to-ack timeout that aborts hung transfers.
module rng_ram_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 9,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_i,
  input  logic [4*NREQ-1:0]  req_we_i,
  input  logic [AW*NREQ-1:0] req_addr_i,
  input  logic [DW*NREQ-1:0] req_wdata_i,
  output logic [NREQ-1:0]    req_ack_o,
  output logic [NREQ-1:0]    req_err_o,
  output logic [DW-1:0]      req_rdata_o,
  output logic               m_cyc_o,
  output logic               m_stb_o,
  output logic [3:0]         m_we_o,
  output logic [AW-1:0]      m_addr_o,
  output logic [DW-1:0]      m_data_o,
  input  logic               m_ack_i,
  input  logic               m_stall_i,
  input  logic [DW-1:0]      m_data_i,
  output logic [1:0]         dbg_state_o
);

  // Handshakes: req_i is a level held until the one-cycle ack/err pulse; the
  // Wishbone strobe is accepted in a cycle with m_stb_o=1 and m_stall_i=0,
  // and the transfer completes on the first m_ack_i seen from acceptance on.
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  localparam int            GW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [GW:0]   NREQ_W = (GW+1)'(NREQ);
  localparam logic [GW-1:0] LAST   = GW'(NREQ - 1);
  localparam logic [7:0]    TMO    = 8'(TIMEOUT);

  state_t          r_state;
  logic [GW-1:0]   r_ptr;
  logic [GW-1:0]   r_gnt;
  logic [7:0]      r_cnt;
  logic            r_cyc;
  logic            r_stb;
  logic [3:0]      r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [DW-1:0]   r_rdata;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_err;

  logic [NREQ-1:0] w_rot;
  logic            w_any;
  logic [GW-1:0]   w_off;
  logic [GW:0]     w_sum;
  logic [GW-1:0]   w_sel;
  logic [GW-1:0]   w_ptr_nxt;
  logic [3:0]      w_we;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_wdata;
  logic [NREQ-1:0] w_gnt_1h;
  logic            w_done;
  logic            w_tmo;

  // Rotate requests so bit 0 is the pointer position; the lowest set bit of
  // the rotated vector is then the round-robin winner's offset from ptr.
  assign w_rot = NREQ'({req_i, req_i} >> r_ptr);

  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_any = 1'b1;
        w_off = GW'(i);
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_sel     = (w_sum >= NREQ_W) ? GW'(w_sum - NREQ_W) : w_sum[GW-1:0];
  assign w_ptr_nxt = (w_sel == LAST) ? '0 : w_sel + GW'(1);

  always_comb begin
    w_we    = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_sel == GW'(i)) begin
        w_we    = req_we_i[4*i +: 4];
        w_addr  = req_addr_i[AW*i +: AW];
        w_wdata = req_wdata_i[DW*i +: DW];
      end
    end
  end

  always_comb begin
    w_gnt_1h = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gnt_1h[i] = (r_gnt == GW'(i));
    end
  end

  // A stalled strobe cannot take an ack; once accepted any ack completes.
  assign w_done = m_ack_i &&
                  (((r_state == S_ISSUE) && !m_stall_i) || (r_state == S_WAIT_ACK));
  assign w_tmo  = (r_cnt + 8'd1) == TMO;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ack   <= '0;
      r_err   <= '0;
    end else begin
      r_ack <= '0;
      r_err <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_sel;
            r_ptr   <= w_ptr_nxt;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT_ACK: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_done) begin
            r_rdata <= m_data_i;
            r_ack   <= w_gnt_1h;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_tmo) begin
            r_err   <= w_gnt_1h;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_state <= S_RESP;
          end else if ((r_state == S_ISSUE) && !m_stall_i) begin
            r_stb   <= 1'b0;
            r_state <= S_WAIT_ACK;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ack_o   = r_ack;
  assign req_err_o   = r_err;
  assign req_rdata_o = r_rdata;
  assign m_cyc_o     = r_cyc;
  assign m_stb_o     = r_stb;
  assign m_we_o      = r_we;
  assign m_addr_o    = r_addr;
  assign m_data_o    = r_wdata;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rng_ram_arbiter.sv
// Bench for rng_ram_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_rng_ram_arbiter;

  localparam int NREQ    = 4;
  localparam int AW      = 9;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;
  localparam int WEW     = 4 * NREQ;
  localparam int AWW     = AW * NREQ;
  localparam int DWW     = DW * NREQ;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NREQ-1:0] req_i = '0;
  logic [WEW-1:0]  req_we_i = '0;
  logic [AWW-1:0]  req_addr_i = '0;
  logic [DWW-1:0]  req_wdata_i = '0;
  logic [NREQ-1:0] req_ack_o;
  logic [NREQ-1:0] req_err_o;
  logic [DW-1:0]   req_rdata_o;
  logic            m_cyc_o;
  logic            m_stb_o;
  logic [3:0]      m_we_o;
  logic [AW-1:0]   m_addr_o;
  logic [DW-1:0]   m_data_o;
  logic            m_ack_i = 1'b0;
  logic            m_stall_i = 1'b0;
  logic [DW-1:0]   m_data_i = '0;
  logic [1:0]      dbg_state_o;

  always #5 clk = ~clk;

  rng_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_i(req_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_rdata_o(req_rdata_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_data_o(m_data_o), .m_ack_i(m_ack_i), .m_stall_i(m_stall_i), .m_data_i(m_data_i),
    .dbg_state_o(dbg_state_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One transfer at a time: md_busy while the Wishbone cycle is open,
  // md_stb until the strobe is accepted, md_resp marks the reply cycle.
  int              md_ptr = 0;
  int              md_g = 0;
  int              md_age = 0;
  int              md_resp = 0;
  int              md_idx = 0;
  bit              md_busy = 1'b0;
  bit              md_stb = 1'b0;
  bit              md_acked = 1'b0;
  logic [3:0]      md_we = '0;
  logic [AW-1:0]   md_addr = '0;
  logic [DW-1:0]   md_wdata = '0;
  logic [DW-1:0]   exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_ptr  = 0;
      md_busy = 1'b0;
      md_stb  = 1'b0;
      md_resp = 0;
      md_age  = 0;
      exp_q.delete();
    end else if (md_resp != 0) begin
      md_resp = 0;
    end else if (md_busy) begin
      md_age++;
      md_acked = m_ack_i && (!md_stb || !m_stall_i);
      if (md_acked) begin
        md_busy = 1'b0;
        md_resp = 1;
        exp_q.push_back(m_data_i);
      end else if (md_age == TIMEOUT) begin
        md_busy = 1'b0;
        md_resp = 2;
      end else if (!m_stall_i) begin
        md_stb = 1'b0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        md_idx = (md_ptr + k) % NREQ;
        if (!md_busy && (((req_i >> md_idx) & NREQ'(1)) != 0)) begin
          md_busy  = 1'b1;
          md_g     = md_idx;
          md_we    = 4'(req_we_i >> (4 * md_idx));
          md_addr  = AW'(req_addr_i >> (AW * md_idx));
          md_wdata = DW'(req_wdata_i >> (DW * md_idx));
        end
      end
      if (md_busy) begin
        md_stb = 1'b1;
        md_age = 0;
        md_ptr = (md_g + 1) % NREQ;
      end
    end
  end

  // ---------------- compare process ----------------
  logic [NREQ-1:0] ce_ack;
  logic [NREQ-1:0] ce_err;
  logic [1:0]      ce_state;

  always @(negedge clk) begin
    if (chk_en) begin
      ce_ack   = (md_resp == 1) ? (NREQ'(1) << md_g) : '0;
      ce_err   = (md_resp == 2) ? (NREQ'(1) << md_g) : '0;
      ce_state = (md_resp != 0) ? 2'd3 : (md_busy ? (md_stb ? 2'd1 : 2'd2) : 2'd0);
      check("m_cyc", m_cyc_o, md_busy);
      check("m_stb", m_stb_o, md_busy && md_stb);
      check("req_ack", req_ack_o, ce_ack);
      check("req_err", req_err_o, ce_err);
      check("state", dbg_state_o, ce_state);
      if (md_busy && md_stb) begin
        check("m_we", m_we_o, md_we);
        check("m_addr", m_addr_o, md_addr);
        check("m_data", m_data_o, md_wdata);
      end
      if (req_ack_o != 0 || md_resp == 1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rdata_q: ack %0h with no expected read data at %0t", req_ack_o, $time);
        end else begin
          check("req_rdata", req_rdata_o, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_we_i    = (req_we_i & ~(WEW'(4'hF) << (4 * i))) | (WEW'(we) << (4 * i));
    req_addr_i  = (req_addr_i & ~(AWW'({AW{1'b1}}) << (AW * i))) | (AWW'(a) << (AW * i));
    req_wdata_i = (req_wdata_i & ~(DWW'({DW{1'b1}}) << (DW * i))) | (DWW'(d) << (DW * i));
    req_i       = req_i | (NREQ'(1) << i);
  endtask

  task automatic clr_req(input int i);
    req_i = req_i & ~(NREQ'(1) << i);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_i     = '0;
    m_ack_i   = 1'b0;
    m_stall_i = 1'b0;
    m_data_i  = '0;
    repeat (2) @(negedge clk);
    check("rst_cyc", m_cyc_o, 0);
    check("rst_stb", m_stb_o, 0);
    check("rst_ack", req_ack_o, 0);
    check("rst_err", req_err_o, 0);
    check("rst_we", m_we_o, 0);
    check("rst_addr", m_addr_o, 0);
    check("rst_data", m_data_o, 0);
    check("rst_rdata", req_rdata_o, 0);
    check("rst_state", dbg_state_o, 0);
    rst    = 1'b0;
    chk_en = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  int              rr_served;
  logic [NREQ-1:0] rr_drop;
  bit              rq_active [NREQ];
  int              hang;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    // Single read, best-case latency.
    do_reset();
    set_req(0, 4'h0, 9'h010, 32'h0);
    tick();
    check("rd_stb", m_stb_o, 1);
    check("rd_addr", m_addr_o, 9'h010);
    check("rd_we", m_we_o, 4'h0);
    tick();
    check("rd_stb_once", m_stb_o, 0);
    check("rd_cyc_wait", m_cyc_o, 1);
    m_ack_i  = 1'b1;
    m_data_i = 32'hDEADBEEF;
    tick();
    m_ack_i  = 1'b0;
    m_data_i = '0;
    check("rd_ack", req_ack_o, 4'b0001);
    check("rd_rdata", req_rdata_o, 32'hDEADBEEF);
    clr_req(0);
    tick();
    check("rd_ack_pulse", req_ack_o, 4'b0000);

    // Round-robin fairness with all four requesters contending.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 4'h0, AW'(16 * i + 1), 32'h0);
    m_ack_i   = 1'b1;
    rr_served = 0;
    rr_drop   = '0;
    for (int c = 0; c < 200 && rr_served < 8; c++) begin
      tick();
      req_i   = req_i | rr_drop;
      rr_drop = '0;
      if (req_ack_o != 0) begin
        check("rr_grant", req_ack_o, NREQ'(1) << (rr_served % NREQ));
        rr_served++;
        rr_drop = req_ack_o;
        req_i   = req_i & ~req_ack_o;
      end
    end
    if (rr_served < 8) begin
      n_checks++;
      n_errors++;
      $display("FAIL rr_count: served %0d expected 8 within 200 cycles", rr_served);
    end
    m_ack_i = 1'b0;
    req_i   = '0;
    tick();
    tick();

    // Stall: strobe and address held six cycles.
    do_reset();
    set_req(3, 4'h0, 9'h0AB, 32'h0);
    tick();
    m_stall_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) m_stall_i = 1'b0;
      check("stall_stb", m_stb_o, 1);
      check("stall_addr", m_addr_o, 9'h0AB);
      tick();
    end
    check("stall_released", m_stb_o, 0);
    m_ack_i  = 1'b1;
    m_data_i = 32'h0BADF00D;
    tick();
    m_ack_i = 1'b0;
    check("stall_ack", req_ack_o, 4'b1000);
    check("stall_rdata", req_rdata_o, 32'h0BADF00D);
    clr_req(3);
    tick();

    // Timeout on requester 2, then requester 3 is served.
    do_reset();
    set_req(2, 4'h0, 9'h022, 32'h0);
    set_req(3, 4'h0, 9'h033, 32'h0);
    tick();
    for (int c = 1; c <= TIMEOUT; c++) begin
      check("tmo_cyc", m_cyc_o, 1);
      check("tmo_err_low", req_err_o, 0);
      tick();
    end
    check("tmo_cyc_drop", m_cyc_o, 0);
    check("tmo_err", req_err_o, 4'b0100);
    check("tmo_no_ack", req_ack_o, 4'b0000);
    clr_req(2);
    tick();
    check("tmo_err_pulse", req_err_o, 4'b0000);
    tick();
    check("tmo_next_stb", m_stb_o, 1);
    check("tmo_next_addr", m_addr_o, 9'h033);
    tick();
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    check("tmo_next_ack", req_ack_o, 4'b1000);
    clr_req(3);
    tick();

    // Write from requester 1.
    do_reset();
    set_req(1, 4'hF, 9'h1FF, 32'hA5A5A5A5);
    tick();
    check("wr_stb", m_stb_o, 1);
    check("wr_we", m_we_o, 4'hF);
    check("wr_addr", m_addr_o, 9'h1FF);
    check("wr_data", m_data_o, 32'hA5A5A5A5);
    tick();
    m_ack_i  = 1'b1;
    m_data_i = 32'h12345678;
    tick();
    m_ack_i = 1'b0;
    check("wr_ack", req_ack_o, 4'b0010);
    clr_req(1);
    tick();

    // Reset while waiting for ack, then service restarts from pointer 0.
    do_reset();
    set_req(2, 4'h0, 9'h0C2, 32'h0);
    tick();
    tick();
    check("mr_cyc_before", m_cyc_o, 1);
    #2 rst = 1'b1;
    #1;
    check("mr_cyc_async", m_cyc_o, 0);
    check("mr_state", dbg_state_o, 0);
    clr_req(2);
    m_ack_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    m_ack_i = 1'b0;
    tick();
    check("mr_no_ack", req_ack_o, 4'b0000);
    set_req(0, 4'h0, 9'h0A0, 32'h0);
    set_req(3, 4'h0, 9'h0A3, 32'h0);
    tick();
    check("mr_ptr0_addr", m_addr_o, 9'h0A0);
    tick();
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    check("mr_ack0", req_ack_o, 4'b0001);
    clr_req(0);
    tick();
    tick();
    check("mr_req3_addr", m_addr_o, 9'h0A3);
    tick();
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    check("mr_ack3", req_ack_o, 4'b1000);
    clr_req(3);
    tick();

    // Random traffic against the model.
    do_reset();
    hang = 0;
    for (int i = 0; i < NREQ; i++) rq_active[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (hang > 0) hang--;
      else if ($urandom_range(0, 99) == 0) hang = $urandom_range(10, 25);
      m_stall_i = ($urandom_range(0, 3) == 0);
      m_ack_i   = (hang == 0) && ($urandom_range(0, 2) == 0);
      m_data_i  = $urandom();
      for (int i = 0; i < NREQ; i++) begin
        if (rq_active[i] && md_resp != 0 && md_g == i) begin
          rq_active[i] = 1'b0;
          clr_req(i);
        end else if (!rq_active[i] && $urandom_range(0, 3) == 0) begin
          rq_active[i] = 1'b1;
          set_req(i, ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0,
                  AW'($urandom()), $urandom());
        end else if (rq_active[i] && md_busy && md_g == i && $urandom_range(0, 7) == 0) begin
          clr_req(i);
        end
      end
    end
    req_i     = '0;
    m_ack_i   = 1'b0;
    m_stall_i = 1'b0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rng_ram_arbiter.md
# rng_ram_arbiter

Round-robin arbiter that shares the single Wishbone port B of the RNG key RAM between up to NREQ requesters, e.g. several SIMON key-fetch FSMs and a debug reader. It sits between the requesters and `rng_ram` port B. Each requester issues one single-beat read or write at a time. The block serialises those transfers, drives the pipelined Wishbone master side, routes ack and read data back to the winner, and aborts hung transfers on a timeout.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 9, address width
- DW, 32, data width
- TIMEOUT, 15, max cycles from strobe issue to ack before abort (1..255)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_i  in  NREQ  per-requester request level; held high until ack/err seen
- req_we_i  in  4*NREQ  byte write enables per requester (0000 = read)
- req_addr_i  in  AW*NREQ  address per requester
- req_wdata_i  in  DW*NREQ  write data per requester
- req_ack_o  out  NREQ  one-cycle completion pulse to the granted requester
- req_err_o  out  NREQ  one-cycle timeout-abort pulse to the granted requester
- req_rdata_o  out  DW  read data, valid while any req_ack_o bit is high
- m_cyc_o, m_stb_o  out  1  Wishbone cycle and strobe
- m_we_o  out  4  Wishbone byte write enables
- m_addr_o  out  AW  Wishbone address
- m_data_o  out  DW  Wishbone write data
- m_ack_i, m_stall_i  in  1  Wishbone ack and stall
- m_data_i  in  DW  Wishbone read data

## Operation
- States: IDLE, ISSUE, WAIT_ACK, RESP.
- IDLE:
  - If any req_i is set, choose the first set bit scanning from the round-robin pointer `ptr` upward with wrap (ptr, ptr+1, …, NREQ-1, 0, …).
  - Latch grant index g, plus that requester's we, addr and wdata.
  - Set ptr = (g+1) mod NREQ, then go to ISSUE.
- ISSUE:
  - m_cyc_o = m_stb_o = 1; m_we_o, m_addr_o and m_data_o come from the latched copies.
  - m_stall_i = 1: stay in ISSUE.
  - m_stall_i = 0: strobe accepted. Go to WAIT_ACK, or straight to RESP if m_ack_i is also 1 that cycle.
- WAIT_ACK:
  - m_cyc_o = 1, m_stb_o = 0.
  - On m_ack_i, capture m_data_i into the rdata register and go to RESP.
- RESP:
  - req_ack_o[g] = 1 for exactly one cycle; req_rdata_o = captured data. Then go to IDLE.
  - The requester must drop req_i in the cycle after it sees ack.
- Timeout:
  - An 8-bit counter clears on entry to ISSUE and increments each cycle in ISSUE or WAIT_ACK.
  - When it reaches TIMEOUT without ack, drop m_cyc_o, pulse req_err_o[g] for one cycle (this is the RESP slot, with ack low) and return to IDLE.
  - ack and timeout in the same cycle: ack wins.
- A requester that drops req_i mid-transfer does not cancel it. The transfer completes and its ack is still pulsed.
- m_ack_i while in IDLE or RESP is ignored.
- Exactly one grant at a time. Write transfers return ack with req_rdata_o = last captured m_data_i.

## Timing
- Reset values: state IDLE, ptr 0, all req_ack_o/req_err_o 0, m_cyc_o/m_stb_o 0, m_we_o 0, m_addr_o 0, m_data_o 0, req_rdata_o 0, counter 0.
- Reset mid-transfer drops m_cyc_o immediately (asynchronously); the pending transfer is lost without ack.
- Best-case latency, req_i high in IDLE at cycle 0:
  - Cycle 1: ISSUE.
  - Cycle 2: WAIT_ACK, with m_ack_i arriving in this cycle.
  - Cycle 3: req_ack_o pulse.
- Back-to-back grants: next ISSUE no earlier than 2 cycles after RESP (RESP → IDLE → ISSUE).
- Grant decision is registered. All outputs are driven from registered state.

## Test plan
- Single read:
  - Stimulus: req_i=0001, addr 0x010, we=0000; RAM acks one cycle after stb with 0xDEADBEEF.
  - Required: m_stb_o for one cycle at addr 0x010, req_ack_o=0001 at cycle 3, req_rdata_o=0xDEADBEEF.
- Round-robin fairness:
  - Stimulus: req_i=1111 held; each requester drops and re-raises after its ack.
  - Required: grant order 0,1,2,3,0,…; no requester is served twice before the others are served once.
- Stall:
  - Stimulus: m_stall_i high for 5 cycles during ISSUE.
  - Required: m_stb_o and the address are held stable for 6 cycles, then the transfer completes normally.
- Timeout:
  - Stimulus: TIMEOUT=15, m_ack_i never asserts for requester 2.
  - Required: m_cyc_o drops after 15 cycles, req_err_o=0100 for one cycle, req_ack_o stays 0, the next requester is then served.
- Write:
  - Stimulus: requester 1, we=1111, addr 0x1FF, data 0xA5A5A5A5.
  - Required: m_we_o=1111 and m_data_o=0xA5A5A5A5 during the strobe; req_ack_o=0010.
- Reset mid-operation:
  - Stimulus: assert rst while in WAIT_ACK.
  - Required: m_cyc_o low in the same cycle, no ack is pulsed, ptr=0, and after release req_i=1000 is served normally.
